// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
//   Shared definitions for the carry-save accumulation sequencer: default
//   datapath/count widths and the sequencer state encoding.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package csa_pkg;

  localparam int WIDTH_DEF = 8;  // operand/result width
  localparam int CNT_W_DEF = 4;  // operand count width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } stateT;

endpackage

// File: rtl/carry_save_adder.sv
// ---------------------------------------------------------------------------
// carry_save_adder
//   Purely combinational 3:2 compressor. Reduces three WIDTH-bit operands to
//   a redundant (sum, carry) pair whose ordinary sum equals a+b+c mod 2^WIDTH.
// Ports
//   a, b, c        in   WIDTH  operands
//   sum            out  WIDTH  bitwise sum a^b^c
//   carry_shifted  out  WIDTH  majority(a,b,c) << 1; the MSB carry falls off,
//                              which is harmless because results wrap anyway
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module carry_save_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry_shifted
);

  logic [WIDTH-1:0] majority;

  assign majority      = (a & b) | (a & c) | (b & c);
  assign sum           = a ^ b ^ c;
  assign carry_shifted = {majority[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/csa_accum_sequencer.sv
// ---------------------------------------------------------------------------
// csa_accum_sequencer
//   Sums a burst of N operands. The running total is kept in carry-save form
//   (sum, carry) so each accepted operand costs one 3:2 compression with no
//   carry propagation; a single '+' in RESOLVE produces the final result.
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
//   where valid & ready are both high. The producer of valid holds it and its
//   data until that edge. in_ready and out_valid are pure decodes of the state
//   register, so neither depends combinationally on in_valid or out_ready.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   start      in   1      begin a burst (sampled only in IDLE)
//   count      in   CNT_W  operand count, latched with start
//   in_valid   in   1      operand valid
//   in_data    in   WIDTH  operand
//   in_ready   out  1      high in ACCUM
//   out_valid  out  1      high in DONE, held until out_ready
//   out_data   out  WIDTH  result register
//   out_ready  in   1      consumer accepts result
//   busy       out  1      high whenever state != IDLE
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module csa_accum_sequencer
  import csa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);

  stateT            state;
  stateT            stateNext;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] sumReg;
  logic [WIDTH-1:0] carryReg;
  logic [WIDTH-1:0] resultReg;
  logic [WIDTH-1:0] csaSum;
  logic [WIDTH-1:0] csaCarry;
  logic             accept;

  // An operand is taken only while accumulating; in_valid elsewhere is ignored.
  assign accept = in_valid && (state == ACCUM);

  carry_save_adder #(
    .WIDTH(WIDTH)
  ) u_csa (
    .a            (sumReg),
    .b            (carryReg),
    .c            (in_data),
    .sum          (csaSum),
    .carry_shifted(csaCarry)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          stateNext = (count == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && (remaining == CNT_W'(1))) begin
          stateNext = RESOLVE;
        end
      end
      RESOLVE: begin
        stateNext = DONE;
      end
      DONE: begin
        if (out_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output decode: every output is a function of registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE:    busy      = 1'b0;
      ACCUM:   in_ready  = 1'b1;
      RESOLVE: ;
      DONE:    out_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  assign out_data = resultReg;

  // Datapath: remaining counter, redundant accumulator, result register.
  // resultReg only changes on a zero-length start or in RESOLVE, so it is
  // stable for the whole DONE phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      sumReg    <= '0;
      carryReg  <= '0;
      resultReg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            remaining <= count;
            sumReg    <= '0;
            carryReg  <= '0;
            if (count == '0) begin
              resultReg <= '0;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            sumReg    <= csaSum;
            carryReg  <= csaCarry;
            remaining <= remaining - CNT_W'(1);
          end
        end
        RESOLVE: begin
          resultReg <= sumReg + carryReg;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
`timescale 1ns/1ps
module tb_csa_accum_sequencer;
  import csa_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];

  csa_accum_sequencer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .count    (count),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs are driven and
  // outputs sampled here, well away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startBurst(input logic [CNT_W-1:0] n);
    start = 1'b1;
    count = n;
    tick();
    start = 1'b0;
    count = CNT_W'($urandom_range(0, 15));
    checkVal("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Present one operand after 'gap' idle cycles and hold it until accepted.
  task automatic sendOperand(input logic [WIDTH-1:0] d, input int gap);
    int guard;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!in_ready) checkVal("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom_range(0, 255));
  endtask

  // Wait for a result, hold off the consumer for holdCycles, optionally
  // pulse start while the result is pending, then accept it.
  task automatic collectResult(input string tag, input int holdCycles, input bit pokeStart);
    int               guard;
    logic [WIDTH-1:0] expd;
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    expd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checkVal({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkVal({tag, "_data"}, {24'd0, out_data}, {24'd0, expd});
    for (int i = 0; i < holdCycles; i++) begin
      if (pokeStart && i == 1) begin
        start = 1'b1;
        count = 4'd7;
      end
      tick();
      start = 1'b0;
      checkVal({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      checkVal({tag, "_hold_data"}, {24'd0, out_data}, {24'd0, expd});
      checkVal({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkVal({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    checkVal({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    count     = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    checkVal("rst_busy", {31'd0, busy}, 32'd0);
    checkVal("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkVal("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("rst_out_data", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    tick();
    checkVal("idle_busy", {31'd0, busy}, 32'd0);

    // 1: 5 + 10 + 3 = 0x12, back-to-back; out_valid one edge after last accept
    exp_q.push_back(8'h12);
    startBurst(4'd3);
    checkVal("t1_in_ready", {31'd0, in_ready}, 32'd1);
    sendOperand(8'h05, 0);
    sendOperand(8'h0A, 0);
    sendOperand(8'h03, 0);
    checkVal("t1_resolve_no_valid", {31'd0, out_valid}, 32'd0);
    checkVal("t1_resolve_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    checkVal("t1_latency_valid", {31'd0, out_valid}, 32'd1);
    collectResult("t1", 0, 1'b0);
    tick();

    // 2: 0xFF + 0xFF + 0x02 = 0x200 -> wraps to 0x00
    exp_q.push_back(8'h00);
    startBurst(4'd3);
    sendOperand(8'hFF, 0);
    sendOperand(8'hFF, 0);
    sendOperand(8'h02, 0);
    collectResult("t2", 1, 1'b0);
    tick();

    // 3: zero-length burst
    exp_q.push_back(8'h00);
    startBurst(4'd0);
    checkVal("t3_in_ready", {31'd0, in_ready}, 32'd0);
    checkVal("t3_valid_next", {31'd0, out_valid}, 32'd1);
    collectResult("t3", 0, 1'b0);
    tick();

    // 4: four 0x01 operands with gaps, consumer stalls 5 cycles, start poked in DONE
    exp_q.push_back(8'h04);
    startBurst(4'd4);
    sendOperand(8'h01, 2);
    sendOperand(8'h01, 0);
    sendOperand(8'h01, 3);
    sendOperand(8'h01, 1);
    collectResult("t4", 5, 1'b1);
    tick();
    checkVal("t4_start_ignored", {31'd0, busy}, 32'd0);

    // 5: reset mid-burst, then a clean burst of 0x10 + 0x20
    startBurst(4'd4);
    sendOperand(8'h40, 0);
    sendOperand(8'h40, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkVal("t5_rst_busy", {31'd0, busy}, 32'd0);
    checkVal("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkVal("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("t5_rst_out_data", {24'd0, out_data}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal("t5_idle_no_valid", {31'd0, out_valid}, 32'd0);
      checkVal("t5_idle_no_accept", {31'd0, in_ready}, 32'd0);
      checkVal("t5_idle_busy", {31'd0, busy}, 32'd0);
    end
    in_valid = 1'b0;
    exp_q.push_back(8'h30);
    startBurst(4'd2);
    sendOperand(8'h10, 0);
    sendOperand(8'h20, 0);
    collectResult("t5", 0, 1'b0);
    tick();

    // 6: maximum burst, 15 x 0x11 = 0xFF
    exp_q.push_back(8'hFF);
    startBurst(4'd15);
    for (int i = 0; i < 15; i++) begin
      sendOperand(8'h11, (i % 3 == 2) ? 1 : 0);
      checkVal("t6_busy", {31'd0, busy}, 32'd1);
    end
    collectResult("t6", 2, 1'b0);

    checkVal("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
